// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared select codes, default widths and loader state encoding
package alu_pkg;

   localparam int DATA_W = 6;
   localparam int SEL_W  = 4;

   localparam logic [3:0] SEL_A = 4'b0001;
   localparam logic [3:0] SEL_B = 4'b0010;

   typedef enum logic [1:0] {
      LOAD_A   = 2'd0,
      LOAD_B   = 2'd1,
      LOAD_SEL = 2'd2,
      ISSUE    = 2'd3
   } load_state_t;

endpackage

// File: rtl/alu_load_reg.sv
// rtl/alu_load_reg.sv - load-enable register, clears on asynchronous active-high reset
module alu_load_reg #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - collects A, B and select words into one held bundle for the ALU mux
// Optional select legality check: ALU_LOADER_SEL_CHECK_EN
module alu_operand_loader
   import alu_pkg::*;
#(
   parameter int DATA_W = alu_pkg::DATA_W,
   parameter int SEL_W  = alu_pkg::SEL_W,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] A_Choice,
   output logic [DATA_W-1:0] B_Choice,
   output logic [SEL_W-1:0]  sel,
   output logic              sel_err,
   output logic [CNT_W-1:0]  txn_count
);

   load_state_t state;
   load_state_t state_nxt;
   logic        in_xfer;
   logic        sel_ok;
   logic        load_a;
   logic        load_b;
   logic        load_sel;

   // Held low while reset is asserted so no word is acknowledged and then dropped.
   assign in_ready  = !reset && (state != ISSUE);
   assign out_valid = (state == ISSUE);
   assign in_xfer   = in_valid && in_ready;

`ifdef ALU_LOADER_SEL_CHECK_EN
   assign sel_ok = (in_data[SEL_W-1:0] == SEL_W'(SEL_A)) ||
                   (in_data[SEL_W-1:0] == SEL_W'(SEL_B));
`else
   assign sel_ok = 1'b1;
`endif

   assign load_a   = in_xfer && (state == LOAD_A);
   assign load_b   = in_xfer && (state == LOAD_B);
   assign load_sel = in_xfer && (state == LOAD_SEL) && sel_ok;

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD_A:   if (load_a)   state_nxt = LOAD_B;
         LOAD_B:   if (load_b)   state_nxt = LOAD_SEL;
         LOAD_SEL: if (load_sel) state_nxt = ISSUE;
         ISSUE:    if (out_ready) state_nxt = LOAD_A;
         default:  state_nxt = LOAD_A;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= LOAD_A;
         txn_count <= '0;
      end else begin
         state <= state_nxt;
         if (out_valid && out_ready)
            txn_count <= txn_count + CNT_W'(1);
      end
   end

`ifdef ALU_LOADER_SEL_CHECK_EN
   logic sel_err_q;

   // Rejected select word is still consumed; flag it for exactly one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sel_err_q <= 1'b0;
      else
         sel_err_q <= in_xfer && (state == LOAD_SEL) && !sel_ok;
   end

   assign sel_err = sel_err_q;
`else
   assign sel_err = 1'b0;
`endif

   alu_load_reg #(.W(DATA_W)) u_reg_a (
      .clk   (clk),
      .reset (reset),
      .load  (load_a),
      .d     (in_data),
      .q     (A_Choice)
   );

   alu_load_reg #(.W(DATA_W)) u_reg_b (
      .clk   (clk),
      .reset (reset),
      .load  (load_b),
      .d     (in_data),
      .q     (B_Choice)
   );

   alu_load_reg #(.W(SEL_W)) u_reg_sel (
      .clk   (clk),
      .reset (reset),
      .load  (load_sel),
      .d     (in_data[SEL_W-1:0]),
      .q     (sel)
   );

endmodule
